// File: rtl/keccak_byte_packer_if.sv
// Byte-stream, core-word and digest signals shared by the packer, its byte
// source and the keccak core.
interface keccak_byte_packer_if #(
  parameter int OUT_W = 512
);
  logic [7:0]       s_byte;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             s_empty_msg;
  logic [63:0]      in;
  logic             in_ready;
  logic             is_last;
  logic [2:0]       byte_num;
  logic             buffer_full;
  logic [OUT_W-1:0] out;
  logic             out_ready;
  logic [OUT_W-1:0] digest;
  logic             digest_valid;

  // Byte source and core side.
  modport master (
    output s_byte, s_valid, s_last, s_empty_msg, buffer_full, out, out_ready,
    input  s_ready, in, in_ready, is_last, byte_num, digest, digest_valid
  );

  // Packer side.
  modport slave (
    input  s_byte, s_valid, s_last, s_empty_msg, buffer_full, out, out_ready,
    output s_ready, in, in_ready, is_last, byte_num, digest, digest_valid
  );
endinterface

// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready byte stream big-endian into 64-bit words for the keccak
// core, then captures the digest on the rising edge of out_ready.
module keccak_byte_packer #(
  parameter int OUT_W = 512
) (
  input  logic                clk,
  input  logic                reset,
  keccak_byte_packer_if.slave bus,
  output logic [1:0]          dbg_state_o
);
  typedef enum logic [1:0] {
    ST_FILL        = 2'd0,
    ST_SEND        = 2'd1,
    ST_SEND_LAST   = 2'd2,
    ST_WAIT_DIGEST = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       last_cnt_q, last_cnt_d;
  logic             pend_last0_q, pend_last0_d;
  logic             s_ready_q, s_ready_d;
  logic [63:0]      in_q, in_d;
  logic             in_ready_q, in_ready_d;
  logic             is_last_q, is_last_d;
  logic [2:0]       byte_num_q, byte_num_d;
  logic             out_ready_prev_q;
  logic [OUT_W-1:0] digest_q, digest_d;
  logic             digest_valid_q, digest_valid_d;
  logic             byte_fire;
  logic             empty_fire;
  logic             out_rise;

  // A byte (with its s_last flag) transfers on a rising edge where s_valid and
  // s_ready are both high; s_ready is high only in FILL and only after reset.
  assign byte_fire  = (state_q == ST_FILL) && s_ready_q && bus.s_valid;
  assign empty_fire = (state_q == ST_FILL) && s_ready_q && !bus.s_valid &&
                      bus.s_empty_msg && (cnt_q == 3'd0);
  assign out_rise   = bus.out_ready && !out_ready_prev_q;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    last_cnt_d     = last_cnt_q;
    pend_last0_d   = pend_last0_q;
    in_d           = in_q;
    in_ready_d     = 1'b0;
    is_last_d      = 1'b0;
    byte_num_d     = 3'd0;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (byte_fire) begin
          // ~cnt equals 7-cnt, so byte k of the word lands in acc[63-8k -: 8].
          acc_d[{~cnt_q, 3'b000} +: 8] = bus.s_byte;
          if (bus.s_last) begin
            cnt_d = 3'd0;
            if (cnt_q == 3'd7) begin
              state_d      = ST_SEND;
              pend_last0_d = 1'b1;
            end else begin
              state_d    = ST_SEND_LAST;
              last_cnt_d = cnt_q + 3'd1;
            end
          end else if (cnt_q == 3'd7) begin
            state_d = ST_SEND;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (empty_fire) begin
          state_d    = ST_SEND_LAST;
          last_cnt_d = 3'd0;
        end
      end
      ST_SEND: begin
        if (!bus.buffer_full) begin
          in_d       = acc_q;
          in_ready_d = 1'b1;
          acc_d      = '0;
          if (pend_last0_q) begin
            state_d      = ST_SEND_LAST;
            last_cnt_d   = 3'd0;
            pend_last0_d = 1'b0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_SEND_LAST: begin
        // acc was cleared after the previous word, so unused low bytes are zero.
        if (!bus.buffer_full) begin
          in_d       = acc_q;
          in_ready_d = 1'b1;
          is_last_d  = 1'b1;
          byte_num_d = last_cnt_q;
          acc_d      = '0;
          state_d    = ST_WAIT_DIGEST;
        end
      end
      ST_WAIT_DIGEST: begin
        if (out_rise) begin
          digest_d       = bus.out;
          digest_valid_d = 1'b1;
          acc_d          = '0;
          state_d        = ST_FILL;
        end
      end
    endcase
    s_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_FILL;
      acc_q            <= '0;
      cnt_q            <= '0;
      last_cnt_q       <= '0;
      pend_last0_q     <= 1'b0;
      s_ready_q        <= 1'b0;
      in_q             <= '0;
      in_ready_q       <= 1'b0;
      is_last_q        <= 1'b0;
      byte_num_q       <= '0;
      out_ready_prev_q <= 1'b0;
      digest_q         <= '0;
      digest_valid_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      last_cnt_q       <= last_cnt_d;
      pend_last0_q     <= pend_last0_d;
      s_ready_q        <= s_ready_d;
      in_q             <= in_d;
      in_ready_q       <= in_ready_d;
      is_last_q        <= is_last_d;
      byte_num_q       <= byte_num_d;
      out_ready_prev_q <= bus.out_ready;
      digest_q         <= digest_d;
      digest_valid_q   <= digest_valid_d;
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.in           = in_q;
  assign bus.in_ready     = in_ready_q;
  assign bus.is_last      = is_last_q;
  assign bus.byte_num     = byte_num_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign dbg_state_o      = state_q;
endmodule

// File: doc/keccak_byte_packer.md
# keccak_byte_packer

Upstream feeder for the `keccak` hash core. It accepts a message as a stream of bytes with a valid/ready handshake and packs them big-endian into 64-bit words. It drives the core's `in`/`in_ready`/`is_last`/`byte_num` word interface and honours `buffer_full` back-pressure. It also captures the digest once the core raises `out_ready`. This block replaces the bench-side byte packing so that RTL and BFM stimulus share one implementation.

## Interface
Parameters:
- `OUT_W`, 512, digest width taken from core `out`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state clears while low.
- `s_byte`  in  8  message byte.
- `s_valid`  in  1  `s_byte`/`s_last` valid.
- `s_last`  in  1  current byte is the final byte of the message.
- `s_ready`  out  1  packer accepts a byte this cycle.
- `s_empty_msg`  in  1  one-cycle request to hash a zero-length message; honoured only in FILL with `cnt`==0.
- `in`  out  64  word to core; first byte of the word in [63:56].
- `in_ready`  out  1  one-cycle word strobe to core.
- `is_last`  out  1  qualifies the `in_ready` word as final.
- `byte_num`  out  3  valid bytes in the final word (0..7); 0 when `is_last`=0.
- `buffer_full`  in  1  core cannot take a word.
- `out`  in  OUT_W  core digest.
- `out_ready`  in  1  core digest valid.
- `digest`  out  OUT_W  captured digest.
- `digest_valid`  out  1  one-cycle pulse when `digest` updates.

## Operation
- Internal state: `acc[63:0]`, `cnt[2:0]` (bytes held), `pend_last0` flag, FSM {FILL, SEND, SEND_LAST, WAIT_DIGEST}.
- FILL: `s_ready`=1. A byte is accepted on `s_valid && s_ready` and written to `acc[63-8*cnt -: 8]`.
  - `cnt`<7 and !`s_last`: `cnt`++.
  - `cnt`==7 and !`s_last`: go to SEND, `cnt`←0.
  - `s_last` and `cnt`<7: go to SEND_LAST with final `byte_num`=`cnt`+1, `cnt`←0.
  - `s_last` and `cnt`==7: go to SEND with `pend_last0`←1, so the full word goes first and an empty final word follows.
  - `s_empty_msg` with `cnt`==0: go to SEND_LAST with `byte_num`=0.
- SEND: `s_ready`=0. In any cycle with `buffer_full`=0, register `in`←`acc`, `in_ready`←1, `is_last`←0, then:
  - if `pend_last0`: go to SEND_LAST with `byte_num`=0 and clear `pend_last0`;
  - otherwise go to FILL.
  - With `buffer_full`=1, hold and issue no strobe.
- SEND_LAST: `s_ready`=0. With `buffer_full`=0, issue `in_ready`=1, `is_last`=1, `byte_num`=saved count, `in`=`acc`, then go to WAIT_DIGEST.
  - Unused low bytes of `in` are zero.
  - `in` content is don't-care for the core when `byte_num`=0 but is driven 0.
- WAIT_DIGEST: `s_ready`=0. On a rising edge of `out_ready` (registered previous value 0, current value 1), set `digest`←`out` and pulse `digest_valid`, clear `acc`, then go to FILL.
- `is_last` is asserted on exactly one strobe per message.
- `in_ready` is never asserted in a cycle where the sampled `buffer_full`=1.
- Between messages the core must be reset externally so that `out_ready` falls. The packer does not re-capture while `out_ready` stays high.
- Reset mid-message: the partial word is discarded and the FSM returns to FILL.

## Timing
- Reset values: `s_ready`=0 while `reset` is low and 1 in the first cycle after release. `in`=0, `in_ready`=0, `is_last`=0, `byte_num`=0, `digest`=0, `digest_valid`=0. FSM=FILL, `cnt`=0, `pend_last0`=0.
- Outputs to the core are registered. Latency from acceptance of the 8th byte (cycle N) to `in_ready` is N+2 with `buffer_full` low.
- Latency is the same from the accepting edge of a final byte (`s_last`) to the `is_last` strobe.
- Maximum throughput: 8 bytes per 9 cycles (one SEND cycle per word).
- `buffer_full` is sampled in SEND/SEND_LAST. The strobe appears on the cycle after the first low sample.
- `digest_valid` pulses one cycle after the sampled `out_ready` rise, with `digest` stable from that cycle.
- `s_ready` drops in the cycle after the byte that completes a word or ends the message.

## Test plan
- 5-byte message "hello" (`s_last` on 'o'), `buffer_full`=0: expect exactly one strobe, `in`=0x68656C6C6F000000, `is_last`=1, `byte_num`=5.
- 8-byte message 0x01..0x08: expect strobe 1 with `in`=0x0102030405060708, `is_last`=0, then strobe 2 with `is_last`=1, `byte_num`=0, `in`=0.
- 9-byte message: expect a full word, then a final word with `byte_num`=1 and byte 9 in [63:56].
- Back-pressure: hold `buffer_full`=1 for 10 cycles while SEND is pending. Expect no `in_ready` during those cycles, then a single strobe 1 cycle after release, and `s_ready` held low throughout.
- Digest capture: drive `out`=OUT_W'hA5…A5 and raise `out_ready` 20 cycles after the last strobe. Expect one `digest_valid` pulse, `digest`=A5…A5, and no second pulse while `out_ready` stays high.
- Assert `reset`=0 after 3 bytes of a message: all outputs go to their reset values immediately. After release, a new 1-byte message yields `byte_num`=1 containing only the new byte.
